ring_wr_cntrl: RTL and testbench

Write-side address controller for the digitizer sample ring buffer, directly upstream of the readout address controller. Writes ADC samples continuously into the ring while armed. On a trigger it writes a programmable number of post-trigger samples, then freezes. It then presents the frozen write pointer as the readout reference address (`ain`) and holds it stable while readout runs.

---
 rtl/ring_wr_cntrl.sv | 94 +++++++++
 tb/tb_ring_wr_cntrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ring_wr_cntrl.sv
// ring_wr_cntrl: write-side address controller for the digitizer sample ring buffer
module ring_wr_cntrl #(
    parameter int SIZE     = 8,
    parameter bit REQ_FULL = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            arm_i,
    input  logic            adc_valid,
    input  logic            trig_i,
    input  logic [SIZE-1:0] posttrig_i,
    input  logic            rd_request,
    output logic            wr_en,
    output logic [SIZE-1:0] wr_addr,
    output logic [SIZE-1:0] ain_o,
    output logic            ro_ready,
    output logic            buf_full,
    output logic [7:0]      trig_miss,
    output logic [1:0]      state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        POST    = 3'd2,
        FROZEN  = 3'd3,
        READOUT = 3'd4
    } state_t;

    state_t          state, state_nx;
    logic [SIZE-1:0] wr_ptr;
    logic [SIZE-1:0] cnt;
    logic            trig_q;
    logic            trig_edge;
    logic            accept;
    logic            miss;
    logic            enter_armed;

    assign trig_edge   = trig_i & ~trig_q;
    // A trigger is only taken while still armed; arm_i low wins and is not a miss.
    assign accept      = (state == ARMED) && arm_i && trig_edge && (buf_full || !REQ_FULL);
    assign miss        = trig_edge && (((state == ARMED) && arm_i && !accept) ||
                                       (state == POST) || (state == FROZEN) || (state == READOUT));
    assign enter_armed = (state_nx == ARMED) && (state != ARMED);
    assign wr_addr     = wr_ptr;
    assign ain_o       = wr_ptr;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = arm_i ? ARMED : IDLE;
            ARMED:   state_nx = !arm_i ? IDLE : !accept ? ARMED : (posttrig_i == '0) ? FROZEN : POST;
            POST:    state_nx = (adc_valid && cnt == SIZE'(1)) ? FROZEN : POST;
            FROZEN:  state_nx = rd_request ? READOUT : FROZEN;
            READOUT: state_nx = rd_request ? READOUT : arm_i ? ARMED : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from the current state; the write strobe passes straight through
    always_comb begin
        wr_en   = adc_valid && (state == ARMED || state == POST);
        state_o = (state == READOUT) ? 2'd3 : state[1:0];
    end

    // Write pointer, wrap flag, post-trigger counter, readout flag and miss counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            cnt       <= '0;
            ro_ready  <= 1'b0;
            buf_full  <= 1'b0;
            trig_miss <= '0;
            trig_q    <= 1'b0;
        end else begin
            trig_q    <= trig_i;
            wr_ptr    <= wr_en ? wr_ptr + SIZE'(1) : wr_ptr;
            buf_full  <= enter_armed ? 1'b0 : (wr_en && wr_ptr == '1) ? 1'b1 : buf_full;
            cnt       <= accept ? posttrig_i : (state == POST && adc_valid) ? cnt - SIZE'(1) : cnt;
            ro_ready  <= (state_nx == FROZEN) || (state_nx == READOUT);
            trig_miss <= (miss && trig_miss != 8'hFF) ? trig_miss + 8'd1 : trig_miss;
        end
    end

endmodule

// File: tb/tb_ring_wr_cntrl.sv
// tb_ring_wr_cntrl: scoreboard bench for ring_wr_cntrl against an event-level model
module tb_ring_wr_cntrl;

    localparam int SIZE     = 8;
    localparam bit REQ_FULL = 1'b1;
    localparam int DEPTH    = 1 << SIZE;
    localparam int IDL = 0, ARM = 1, PST = 2, FRZ = 3, RDO = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            arm_i = 1'b0;
    logic            adc_valid = 1'b0;
    logic            trig_i = 1'b0;
    logic [SIZE-1:0] posttrig_i = '0;
    logic            rd_request = 1'b0;
    logic            wr_en;
    logic [SIZE-1:0] wr_addr;
    logic [SIZE-1:0] ain_o;
    logic            ro_ready;
    logic            buf_full;
    logic [7:0]      trig_miss;
    logic [1:0]      state_o;

    ring_wr_cntrl #(.SIZE(SIZE), .REQ_FULL(REQ_FULL)) dut (
        .clk(clk), .rst_n(rst_n), .arm_i(arm_i), .adc_valid(adc_valid), .trig_i(trig_i),
        .posttrig_i(posttrig_i), .rd_request(rd_request), .wr_en(wr_en), .wr_addr(wr_addr),
        .ain_o(ain_o), .ro_ready(ro_ready), .buf_full(buf_full), .trig_miss(trig_miss),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int we;
        int addr;
        int st;
        int ro;
        int full;
        int miss;
    } exp_t;

    exp_t sq[$];
    int   wq[$];
    int   tests = 0;
    int   fails = 0;

    // Model: total writes ever (since reset), wraps counted at arming, event end as a write count
    int m_phase = IDL;
    int m_total = 0;
    int m_base  = 0;
    int m_end   = 0;
    int m_miss  = 0;
    bit m_prev  = 1'b0;

    function automatic bit m_full();
        return (m_total / DEPTH) > m_base;
    endfunction

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endfunction

    task automatic cyc(input bit a, input bit v, input bit t, input int p, input bit r, input bit rn);
        exp_t e;
        bit   edge_t;
        @(negedge clk);
        arm_i      = a;
        adc_valid  = v;
        trig_i     = t;
        posttrig_i = p[SIZE-1:0];
        rd_request = r;
        rst_n      = rn;
        e.we   = (v && (m_phase == ARM || m_phase == PST)) ? 1 : 0;
        e.addr = m_total % DEPTH;
        e.st   = (m_phase == RDO) ? 3 : m_phase;
        e.ro   = (m_phase == FRZ || m_phase == RDO) ? 1 : 0;
        e.full = m_full() ? 1 : 0;
        e.miss = m_miss;
        sq.push_back(e);
        if (e.we != 0) wq.push_back(e.addr);
        edge_t = t && !m_prev;
        if (!rn) begin
            m_phase = IDL; m_total = 0; m_base = 0; m_end = 0; m_miss = 0; m_prev = 1'b0;
        end else begin
            case (m_phase)
                IDL: if (a) begin m_phase = ARM; m_base = m_total / DEPTH; end
                ARM: begin
                    if (!a) m_phase = IDL;
                    else if (edge_t && (m_full() || !REQ_FULL)) begin
                        m_end   = m_total + (v ? 1 : 0) + p;
                        m_phase = (p == 0) ? FRZ : PST;
                    end else if (edge_t) m_miss = (m_miss < 255) ? m_miss + 1 : 255;
                    if (v) m_total++;
                end
                PST: begin
                    if (edge_t) m_miss = (m_miss < 255) ? m_miss + 1 : 255;
                    if (v) begin
                        m_total++;
                        if (m_total == m_end) m_phase = FRZ;
                    end
                end
                FRZ: begin
                    if (edge_t) m_miss = (m_miss < 255) ? m_miss + 1 : 255;
                    if (r) m_phase = RDO;
                end
                default: begin
                    if (edge_t) m_miss = (m_miss < 255) ? m_miss + 1 : 255;
                    if (!r) begin
                        m_phase = a ? ARM : IDL;
                        if (a) m_base = m_total / DEPTH;
                    end
                end
            endcase
            m_prev = t;
        end
    endtask

    // Keep writing while armed until the ring is full and the pointer sits at target
    task automatic run_to(input int target);
        int n = 0;
        while (!(m_phase == ARM && m_full() && m_total % DEPTH == target) && n < 2000) begin
            cyc(1, 1, 0, 0, 0, 1);
            n++;
        end
        tests++;
        if (n >= 2000) begin
            fails++;
            $display("FAIL run_to: pointer %0d never reached %0d", m_total % DEPTH, target);
        end
    endtask

    // Monitor: per-cycle status from the status queue, write addresses from the write queue
    exp_t me;
    always @(negedge clk) begin
        #2;
        if (sq.size() > 0) begin
            me = sq.pop_front();
            chk("wr_en", 32'(wr_en), me.we);
            chk("wr_addr", 32'(wr_addr), me.addr);
            chk("ain_o", 32'(ain_o), me.addr);
            chk("state_o", 32'(state_o), me.st);
            chk("ro_ready", 32'(ro_ready), me.ro);
            chk("buf_full", 32'(buf_full), me.full);
            chk("trig_miss", 32'(trig_miss), me.miss);
        end
        if (wr_en === 1'b1) begin
            if (wq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_write: unexpected write at addr %0d", wr_addr);
            end else chk("sb_write_addr", 32'(wr_addr), wq.pop_front());
        end
    end

    initial begin
        bit a, v, t, r, rn;
        int p;
        repeat (2) @(posedge clk);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // free-running acquisition past one wrap
        for (int i = 0; i < 300; i++) cyc(1, 1, 0, 0, 0, 1);
        // early trigger rejected, then event at pointer 100 with 16 post samples
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 0, 1);
        cyc(1, 1, 1, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 1);
        run_to(100);
        cyc(1, 1, 1, 16, 0, 1);
        for (int i = 0; i < 16; i++) cyc(1, 1, 0, 0, 0, 1);
        // frozen: strobes ignored, trigger edges counted, then readout
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 1, 0, 0, 1);
            cyc(1, 1, 0, 0, 0, 1);
        end
        for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 1, 1);
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        // zero post-trigger event at the top of the ring
        run_to(255);
        cyc(1, 1, 1, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1, 1);
        cyc(1, 0, 0, 0, 0, 1);
        // reset mid-POST and mid-READOUT
        run_to(50);
        cyc(1, 1, 1, 10, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        run_to(20);
        cyc(1, 1, 1, 2, 0, 1);
        cyc(1, 1, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1, 1);
        cyc(1, 0, 0, 0, 1, 1);
        cyc(1, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1);
        // disarm racing a trigger, then disarm during POST
        run_to(30);
        cyc(0, 0, 1, 4, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        run_to(40);
        cyc(1, 1, 1, 8, 0, 1);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        // randomized traffic
        a = 1; t = 0; r = 0;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 399) == 0) a = !a;
            if ($urandom_range(0, 7) == 0) t = !t;
            if ($urandom_range(0, 9) == 0) r = !r;
            v  = $urandom_range(0, 3) != 0;
            p  = $urandom_range(0, 12);
            rn = $urandom_range(0, 499) != 0;
            if (!rn) v = 0;
            cyc(a, v, t, p, r, rn);
        end
        cyc(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
